// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide controller.
// Opcodes, FSM states, divider iteration count and sign helpers.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL  = 3'd0;
    localparam logic [2:0] MD_DIV  = 3'd1;
    localparam logic [2:0] MD_MTHI = 3'd2;
    localparam logic [2:0] MD_MTLO = 3'd3;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } md_state_e;

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        if (neg) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider datapath on operand magnitudes.
// The quotient register starts out holding the dividend and shifts quotient bits in from the right.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [32:0] shifted_s;
    logic [31:0] diff_s;
    logic        fits_s;

    // Trial subtract of the divisor from the shifted partial remainder.
    // A zero divisor always fits, which yields an all-ones quotient and remainder |a|.
    always_comb begin
        shifted_s = {rem_r, quo_r[31]};
        fits_s    = (shifted_s >= {1'b0, dvs_r});
        diff_s    = shifted_s[31:0] - dvs_r;
    end

    // Remainder/quotient/divisor registers: load on start, one iteration per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_r <= 32'd0;
            rem_r <= 32'd0;
            dvs_r <= 32'd0;
        end else if (start) begin
            quo_r <= abs_if(a, sign);
            rem_r <= 32'd0;
            dvs_r <= abs_if(b, sign);
        end else if (step) begin
            rem_r <= fits_s ? diff_s : shifted_s[31:0];
            quo_r <= {quo_r[30:0], fits_s};
        end else begin
            quo_r <= quo_r;
            rem_r <= rem_r;
            dvs_r <= dvs_r;
        end
    end

    assign quo = quo_r;
    assign rem = rem_r;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller owning HI/LO: fixed-latency multiplier pipeline,
// iterative divider sequencing, MTHI/MTLO writes and cancel handling.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  op_i,
    input  logic        sign_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    md_state_e   state_r;
    md_state_e   state_s;
    logic [4:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        neg_q_r;
    logic        neg_rem_r;
    logic [63:0] mul_pipe_r [MUL_LAT];

    logic        accept_s;
    logic        div_start_s;
    logic        div_step_s;
    logic        mul_wr_s;
    logic        div_wr_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;

    assign accept_s = valid_i && (state_r == ST_IDLE);

    // Sign-extended operands; the low 64 bits of the product are then correct for both signednesses.
    always_comb begin
        mul_a_s = {{32{sign_i & a_i[31]}}, a_i};
        mul_b_s = {{32{sign_i & b_i[31]}}, b_i};
        prod_s  = mul_a_s * mul_b_s;
    end

    // Next-state and control decode; cancel outranks completion in every busy state.
    always_comb begin
        state_s     = state_r;
        div_start_s = 1'b0;
        div_step_s  = 1'b0;
        mul_wr_s    = 1'b0;
        div_wr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_i)
                        MD_MUL:  state_s = ST_MUL;
                        MD_DIV: begin
                            state_s     = ST_DIV;
                            div_start_s = 1'b1;
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cancel_i) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 5'd0) begin
                    mul_wr_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (cancel_i) begin
                    state_s = ST_IDLE;
                end else begin
                    div_step_s = 1'b1;
                    state_s    = (cnt_r == 5'd0) ? ST_FIN : ST_DIV;
                end
            end
            ST_FIN: begin
                if (cancel_i) begin
                    state_s = ST_IDLE;
                end else begin
                    div_wr_s = 1'b1;
                    state_s  = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy flag derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Iteration counter: loaded on accept, counts down while MUL/DIV runs, cleared on return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 5'd0;
        end else if (accept_s && (op_i == MD_MUL)) begin
            cnt_r <= 5'(MUL_LAT - 1);
        end else if (accept_s && (op_i == MD_DIV)) begin
            cnt_r <= 5'(DIV_ITERS - 1);
        end else if ((state_r != ST_IDLE) && (state_s == ST_IDLE)) begin
            cnt_r <= 5'd0;
        end else if ((cnt_r != 5'd0) && ((state_r == ST_MUL) || (state_r == ST_DIV))) begin
            cnt_r <= cnt_r - 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Multiplier pipeline: stage 0 captures the product at accept, later stages just shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe_r[i] <= 64'd0;
            end
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                mul_pipe_r[i] <= mul_pipe_r[i-1];
            end
            if (accept_s && (op_i == MD_MUL)) begin
                mul_pipe_r[0] <= prod_s;
            end else begin
                mul_pipe_r[0] <= mul_pipe_r[0];
            end
        end
    end

    // Divide sign fix-up flags captured at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (accept_s && (op_i == MD_DIV)) begin
            neg_q_r   <= sign_i & (a_i[31] ^ b_i[31]);
            neg_rem_r <= sign_i & a_i[31];
        end else begin
            neg_q_r   <= neg_q_r;
            neg_rem_r <= neg_rem_r;
        end
    end

    div_iter u_div_iter (
        .clk   (clk),
        .reset (reset),
        .start (div_start_s),
        .step  (div_step_s),
        .a     (a_i),
        .b     (b_i),
        .sign  (sign_i),
        .quo   (div_quo_s),
        .rem   (div_rem_s)
    );

    // Architectural HI/LO and the completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= mul_wr_s | div_wr_s;
            if (accept_s && (op_i == MD_MTHI)) begin
                hi_r <= a_i;
            end else if (accept_s && (op_i == MD_MTLO)) begin
                lo_r <= a_i;
            end else if (mul_wr_s) begin
                {hi_r, lo_r} <= mul_pipe_r[MUL_LAT-1];
            end else if (div_wr_s) begin
                lo_r <= neg_if(div_quo_s, neg_q_r);
                hi_r <= neg_if(div_rem_s, neg_rem_r);
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign ready_o = ~busy_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign hi_o    = hi_r;
    assign lo_o    = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model with per-cycle
// comparison, plus directed vectors with hand-computed expectations.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic        sign_i = 1'b0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        cancel_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_pass = 0;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .sign_i   (sign_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cancel_i (cancel_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic definition.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic sg,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ma, mb, q, r;
        logic [31:0] q32, r32;
        if (op == MD_MUL) begin
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            return {32'd0, a} * {32'd0, b};
        end
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        ma = (sa < 0) ? 64'(-sa) : 64'(sa);
        mb = (sb < 0) ? 64'(-sb) : 64'(sb);
        if (mb == 64'd0) begin
            q = 64'h0000_0000_FFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        q32 = q[31:0];
        r32 = r[31:0];
        if (sg && (a[31] ^ b[31])) q32 = -q32;
        if (sg && a[31]) r32 = -r32;
        return {r32, q32};
    endfunction

    // Behavioural model: one pending operation with a completion cycle number.
    int          cyc = 0;
    logic        m_pend = 1'b0;
    int          m_end = 0;
    logic [63:0] m_res = 64'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_done = 1'b0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_pend && cancel_i) begin
                m_pend = 1'b0;
            end else if (m_pend && cyc == m_end) begin
                {m_hi, m_lo} = m_res;
                m_done = 1'b1;
                m_pend = 1'b0;
            end else if (!m_pend && valid_i) begin
                case (op_i)
                    MD_MUL: begin
                        m_res = model_result(op_i, sign_i, a_i, b_i);
                        m_pend = 1'b1;
                        m_end = cyc + LAT;
                    end
                    MD_DIV: begin
                        m_res = model_result(op_i, sign_i, a_i, b_i);
                        m_pend = 1'b1;
                        m_end = cyc + DIV_ITERS + 1;
                    end
                    MD_MTHI: m_hi = a_i;
                    MD_MTLO: m_lo = a_i;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("hi_cyc", {32'd0, hi_o}, {32'd0, m_hi});
            chk("lo_cyc", {32'd0, lo_o}, {32'd0, m_lo});
            chk("busy_cyc", {63'd0, busy_o}, {63'd0, m_pend});
            chk("ready_cyc", {63'd0, ready_o}, {63'd0, ~m_pend});
            chk("done_cyc", {63'd0, done_o}, {63'd0, m_done});
        end
    end

    task automatic run_op(input logic [2:0] op, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int cancel_at,
                          output int done_cyc, output int busy_cyc);
        int n;
        @(negedge clk);
        valid_i = 1'b1; op_i = op; sign_i = sg; a_i = a; b_i = b;
        @(negedge clk);
        valid_i = 1'b0; a_i = 32'hDEAD_BEEF; b_i = 32'hDEAD_BEEF; sign_i = ~sg;
        done_cyc = 0;
        busy_cyc = 0;
        n = 1;
        while (n <= 80) begin
            if (busy_o) busy_cyc++;
            if (done_o) done_cyc = n;
            if (!busy_o) break;
            cancel_i = (n == cancel_at);
            @(negedge clk);
            n++;
        end
        cancel_i = 1'b0;
        chk("op_bound", {63'd0, (n <= 80)}, 64'd1);
    endtask

    int dc, bc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        reset = 1'b0;

        run_op(MD_MUL, 1'b1, 32'hFFFF_FFFE, 32'd3, 0, dc, bc);
        chk("mult_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo_o}, 64'hFFFF_FFFA);
        chk("mult_done_lat", 64'(dc), 64'd3);
        chk("mult_busy_len", 64'(bc), 64'd2);
        chk("model_mult", model_result(MD_MUL, 1'b1, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);

        run_op(MD_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, dc, bc);
        chk("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

        run_op(MD_DIV, 1'b0, 32'd100, 32'd7, 0, dc, bc);
        chk("divu_lo", {32'd0, lo_o}, 64'd14);
        chk("divu_hi", {32'd0, hi_o}, 64'd2);
        chk("divu_busy_len", 64'(bc), 64'd33);
        chk("divu_done_lat", 64'(dc), 64'd34);

        run_op(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, dc, bc);
        chk("div_neg_lo", {32'd0, lo_o}, 64'hFFFF_FFFD);
        chk("div_neg_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
        chk("div_neg_busy_len", 64'(bc), 64'd33);

        run_op(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, dc, bc);
        chk("div_ovf_lo", {32'd0, lo_o}, 64'h8000_0000);
        chk("div_ovf_hi", {32'd0, hi_o}, 64'd0);

        run_op(MD_DIV, 1'b0, 32'd5, 32'd0, 0, dc, bc);
        chk("divu_z_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
        chk("divu_z_hi", {32'd0, hi_o}, 64'd5);

        run_op(MD_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, 0, dc, bc);
        chk("div_z_lo", {32'd0, lo_o}, 64'd1);
        chk("div_z_hi", {32'd0, hi_o}, 64'hFFFF_FFFB);
        chk("model_div_z", model_result(MD_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0), 64'hFFFF_FFFB_0000_0001);

        @(negedge clk);
        valid_i = 1'b1; op_i = MD_MTHI; a_i = 32'h1234;
        @(negedge clk);
        op_i = MD_MTLO; a_i = 32'h5678;
        chk("mthi_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        chk("mt_hi", {32'd0, hi_o}, 64'h1234);
        chk("mt_lo", {32'd0, lo_o}, 64'h5678);
        chk("mtlo_busy", {63'd0, busy_o}, 64'd0);

        run_op(MD_DIV, 1'b0, 32'd1000, 32'd3, 10, dc, bc);
        chk("cancel_busy_len", 64'(bc), 64'd10);
        chk("cancel_no_done", 64'(dc), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_hi", {32'd0, hi_o}, 64'h1234);
        chk("cancel_lo", {32'd0, lo_o}, 64'h5678);

        @(negedge clk);
        valid_i = 1'b1; op_i = MD_MUL; sign_i = 1'b0; a_i = 32'd5; b_i = 32'd5;
        @(negedge clk);
        valid_i = 1'b0;
        chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_hi", {32'd0, hi_o}, 64'd0);
        chk("mid_rst_lo", {32'd0, lo_o}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        chk("mid_rst_ready", {63'd0, ready_o}, 64'd1);
        chk("mid_rst_done", {63'd0, done_o}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_hi", {32'd0, hi_o}, 64'd0);
        chk("post_rst_lo", {32'd0, lo_o}, 64'd0);

        run_op(MD_MUL, 1'b1, 32'd3, 32'd4, 0, dc, bc);
        chk("recover_hilo", {hi_o, lo_o}, 64'd12);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller that owns the architectural HI/LO registers. It sits beside the execute stage and receives MULT/MULTU/DIV/DIVU/MTHI/MTLO requests through a valid/ready handshake. It sequences a fixed-latency multiplier and an iterative radix-2 divider, and exposes HI/LO plus a busy flag. Execute stalls MFHI/MFLO on that flag.

## Interface
Parameters:
- MUL_LAT, 2, multiply latency in clock edges after accept (legal range 1..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid_i  in  1  request present this cycle.
- ready_o  out  1  controller can accept a request (state IDLE).
- op_i  in  3  request opcode: MUL, DIV, MTHI, MTLO (encodings in package).
- sign_i  in  1  signed operation (MULT/DIV); ignored for MTHI/MTLO.
- a_i  in  32  rs operand / dividend / MTHI-MTLO data.
- b_i  in  32  rt operand / divisor.
- cancel_i  in  1  exception flush; aborts an in-flight MUL/DIV.
- busy_o  out  1  MUL/DIV in flight; HI/LO stale.
- done_o  out  1  one-cycle pulse in the cycle after HI/LO are updated by MUL/DIV.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.

## Operation
- Accept: valid_i && ready_o sampled at edge E0. Operands and opcode are latched. The requester must hold its inputs only until accept.
- States:
  - IDLE: ready_o=1, busy_o=0.
  - MUL: counter runs from MUL_LAT-1 down to 0.
  - DIV: 32 iterations, counter 31..0.
  - FIN: divide sign fix-up and HI/LO write.
- MTHI/MTLO: written at E0 and stay in IDLE. MTHI writes HI only; MTLO writes LO only.
- MUL: computes the 64-bit product, signed or unsigned per sign_i. {HI,LO} is written at edge E(MUL_LAT). Return to IDLE.
- DIV:
  - Restoring radix-2 on |a| and |b|; abs is taken only when sign_i=1.
  - Each edge shifts the partial remainder left, performs a trial subtract of |b|, and shifts the quotient bit in.
  - FIN negates the quotient if sign_i && (a[31]^b[31]), and negates the remainder if sign_i && a[31].
  - LO=quotient and HI=remainder, written at the edge leaving FIN.
- Divide by zero gives a deterministic result:
  - Raw quotient 0xFFFFFFFF, raw remainder |a|.
  - The sign fix then applies as normal.
- cancel_i in MUL/DIV/FIN: next edge goes to IDLE, HI/LO unchanged, no done_o. cancel_i in IDLE has no effect; it does not block a simultaneous accept. cancel_i has priority over completion in the same cycle.
- busy_o = state != IDLE; ready_o = state == IDLE.

## Timing
- Reset values: state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, ready_o=1, counters 0.
- MUL:
  - busy_o is high for cycles E0+..E(MUL_LAT).
  - New HI/LO are visible in the cycle after E(MUL_LAT), which is also the cycle done_o is high.
  - ready_o is high in that same cycle, so back-to-back requests are allowed.
- DIV:
  - Iterations run on edges E1..E32, and FIN writes at E33.
  - busy_o is high for 33 cycles. Results and done_o appear in the cycle after E33.
- MTHI/MTLO: value visible the cycle after E0; no busy_o, no done_o.
- Reset asserted mid-operation: immediate asynchronous return to reset values. The partial result is discarded.
- hi_o/lo_o are register outputs with no combinational path from any input.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings MD_MUL=0, MD_DIV=1, MD_MTHI=2, MD_MTLO=3;
  - state encoding;
  - the DIV_ITERS=32 constant.
- One sub-module, div_iter: radix-2 restoring datapath (remainder/quotient registers, trial subtract), driven by start/step signals from the controller FSM. The multiplier is an inferred a*b product followed by a MUL_LAT-deep register pipeline inside muldiv_ctrl.

## Test plan
- MULT: a=0xFFFFFFFE (-2), b=3, signed → HI=0xFFFFFFFF, LO=0xFFFFFFFA. done_o arrives exactly MUL_LAT+1 cycles after accept.
- DIVU: 100/7 → LO=14, HI=2. DIV: -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. busy_o is high for exactly 33 cycles.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero:
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV -5/0 → LO=0x00000001, HI=0xFFFFFFFB.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → HI=0x1234, LO=0x5678, busy_o never high.
- Cancel:
  - Start DIV, assert cancel_i at iteration 10 → IDLE next cycle, HI/LO retain prior values, no done_o.
  - Assert reset mid-MUL → all outputs return to reset values immediately.
